// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;

  localparam int unsigned SPI_WIDTH       = 16;
  localparam int unsigned SPI_SYNC_STAGES = 2;
  localparam int unsigned SPI_CNT_W       = $clog2(SPI_WIDTH + 2);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop input synchronizer with one history flop for edge detection.
// Edges are suppressed until the chain and history hold real samples taken
// after reset, so a level already present at reset release is not an edge.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic [STAGES:0]   vld_q;

  // Synchronizer chain, history flop and post-reset fill tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din_i};
      hist_q <= sync_q[STAGES-1];
      vld_q  <= {vld_q[STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = vld_q[STAGES] & sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = vld_q[STAGES] & ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: receives one WIDTH-bit command per SS_n frame while
// shifting out a response word latched at frame start.
module spi_slave_resp
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = SPI_WIDTH,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rdy,
  input  logic             clr_rdy,
  output logic             frame_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  logic ss_rise, ss_fall, ss_level_unused;
  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic mosi_level, mosi_unused_rise, mosi_unused_fall;

  spi_state_e       state_q;
  logic [WIDTH-2:0] tx_shift_q;   // response bits still to send after MISO
  logic [WIDTH-1:0] rx_shift_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             miso_q;
  logic             miso_oe_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rdy_q;
  logic             frame_err_q;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .din_i   (SS_n),
    .level_o (ss_level_unused),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .din_i   (SCLK),
    .level_o (sclk_level_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .din_i   (MOSI),
    .level_o (mosi_level),
    .rise_o  (mosi_unused_rise),
    .fall_o  (mosi_unused_fall)
  );

  // Frame FSM with shift registers, bit counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_data_q   <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // A frame completion below overrides this clear.
      if (clr_rdy) rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            miso_q     <= tx_data[WIDTH-1];
            tx_shift_q <= tx_data[WIDTH-2:0];
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            miso_oe_q  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q   <= IDLE;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            if (bit_cnt_q == CNT_W'(WIDTH)) begin
              rx_data_q <= rx_shift_q;
              rdy_q     <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[WIDTH-2:0], mosi_level};
              if (bit_cnt_q != CNT_W'(WIDTH + 1)) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            // A fall before the first rise is a glitch and must not shift.
            if (sclk_fall && (bit_cnt_q != '0)) begin
              miso_q     <= tx_shift_q[WIDTH-2];
              tx_shift_q <= {tx_shift_q[WIDTH-3:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MISO      = miso_q;
  assign MISO_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_resp.sv
// Scoreboard bench for spi_slave_resp: a bit-banged SPI master drives frames,
// a monitor checks every completion/error event against queued expectations.
module tb_spi_slave_resp;
  import spi_pkg::*;

  localparam int W  = SPI_WIDTH;
  localparam int SS = SPI_SYNC_STAGES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ss_n = 1'b1;
  logic         sclk = 1'b0;
  logic         mosi = 1'b0;
  logic         clr_rdy = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         miso, miso_oe, rdy, frame_err;
  logic [W-1:0] rx_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit           is_err;
    logic [W-1:0] data;
    int           t_cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: what the receiver should be holding.
  logic [W-1:0] model_rx  = '0;
  bit           model_rdy = 1'b0;

  spi_slave_resp #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (ss_n),
    .SCLK      (sclk),
    .MOSI      (mosi),
    .MISO      (miso),
    .MISO_oe   (miso_oe),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rdy       (rdy),
    .clr_rdy   (clr_rdy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor side of the scoreboard: one expectation per observed event.
  task automatic pop_check(input bit is_err);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got err=%0b at cyc %0d want no event", is_err, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_err != is_err) begin
        bad++;
        $display("FAIL event_kind: got err=%0b want err=%0b", is_err, e.is_err);
      end else if (!is_err && (rx_data !== e.data)) begin
        bad++;
        $display("FAIL rx_data_event: got %h want %h", rx_data, e.data);
      end else if ((cyc - e.t_cyc) != SS + 1) begin
        bad++;
        $display("FAIL event_latency: got %0d want %0d", cyc - e.t_cyc, SS + 1);
      end
    end
  endtask

  initial begin
    logic         rdy_p = 1'b0;
    logic [W-1:0] rx_p  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err === 1'b1) pop_check(1'b1);
        if (rdy === 1'b1 && (rdy_p !== 1'b1 || rx_data !== rx_p)) pop_check(1'b0);
      end
      rdy_p = rdy;
      rx_p  = rx_data;
    end
  end

  // Bit-banged mode-0 master; optionally ends the frame and queues the outcome.
  task automatic spi_frame(input logic [W-1:0] cmd, input int nbits, input int ph,
                           input bit end_frame, input bit clr_at_end,
                           input bit chg_tx, input logic [W-1:0] new_tx,
                           output logic [W-1:0] resp, output logic [W-1:0] exp_resp,
                           output bit oe_ok);
    exp_resp = tx_data;
    resp     = '0;
    oe_ok    = 1'b1;
    ss_n     = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < W) ? cmd[W-1-i] : 1'($urandom_range(0, 1));
      wait_clk(ph);
      if (i < W) resp = {resp[W-2:0], miso};
      oe_ok = oe_ok & (miso_oe === 1'b1);
      sclk = 1'b1;
      wait_clk(ph);
      sclk = 1'b0;
      if (chg_tx && i == 7) tx_data = new_tx;
    end
    mosi = 1'b0;
    wait_clk(ph);
    if (end_frame) begin
      ss_n = 1'b1;
      exp_q.push_back('{is_err: (nbits != W), data: cmd, t_cyc: cyc});
      if (nbits == W) begin
        model_rx  = cmd;
        model_rdy = 1'b1;
      end
      if (clr_at_end) begin
        repeat (2) @(posedge clk);
        #1 clr_rdy = 1'b1;
        wait_clk(1);
        clr_rdy = 1'b0;
      end
    end
  endtask

  task automatic clear_rdy();
    clr_rdy = 1'b1;
    wait_clk(1);
    clr_rdy   = 1'b0;
    model_rdy = 1'b0;
    check1("clr_rdy_alone", rdy, 1'b0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout at cyc %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] resp, eresp, c1, c2, orig;
    bit           oe_ok;
    int           nb, ph;

    wait_clk(3);
    check1("rst_miso", miso, 1'b0);
    check1("rst_miso_oe", miso_oe, 1'b0);
    check1("rst_rdy", rdy, 1'b0);
    check("rst_rx_data", rx_data, '0);
    check1("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    wait_clk(3);

    // Full frame.
    tx_data = 16'hA5C3;
    spi_frame(16'h1234, 16, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    check("full_miso_word", resp, eresp);
    check1("full_oe", oe_ok, 1'b1);
    wait_clk(6);
    check("full_rx_data", rx_data, model_rx);
    check1("full_rdy", rdy, model_rdy);
    check1("full_frame_err", frame_err, 1'b0);

    // Short frame keeps previous data and rdy.
    spi_frame(16'hFFFF, 12, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    wait_clk(6);
    check("short_rx_data", rx_data, model_rx);
    check1("short_rdy", rdy, model_rdy);

    // Long frame errors, next good frame lands.
    clear_rdy();
    spi_frame(16'(W'($urandom)), 17, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    check("long_miso_word", resp, eresp);
    wait_clk(6);
    check1("long_rdy", rdy, model_rdy);
    spi_frame(16'h00FF, 16, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    wait_clk(6);
    check("after_long_rx", rx_data, model_rx);
    check1("after_long_rdy", rdy, model_rdy);

    // Handshake: clr_rdy coinciding with completion loses to the set.
    clear_rdy();
    spi_frame(16'hBEEF, 16, 8, 1, 1, 0, '0, resp, eresp, oe_ok);
    wait_clk(4);
    check1("coincide_rdy", rdy, model_rdy);
    check("coincide_rx", rx_data, model_rx);

    // Reset mid-frame, with SS_n still low when reset releases.
    spi_frame(16'h3C3C, 8, 8, 0, 0, 0, '0, resp, eresp, oe_ok);
    rst = 1'b1;
    #1;
    model_rx  = '0;
    model_rdy = 1'b0;
    check1("midrst_miso", miso, 1'b0);
    check1("midrst_miso_oe", miso_oe, 1'b0);
    check1("midrst_rdy", rdy, model_rdy);
    check("midrst_rx", rx_data, model_rx);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(10);
    check1("ss_low_at_release_oe", miso_oe, 1'b0);
    ss_n = 1'b1;
    wait_clk(4);
    spi_frame(16'h0F0F, 16, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    check("postrst_miso_word", resp, eresp);
    wait_clk(6);
    check("postrst_rx", rx_data, model_rx);

    // Back-to-back frames with tx_data changed inside the first.
    clear_rdy();
    orig    = 16'hC0DE;
    tx_data = orig;
    c1      = 16'h1357;
    c2      = 16'h2468;
    spi_frame(c1, 16, 8, 1, 0, 1, 16'h5555, resp, eresp, oe_ok);
    check("b2b_first_resp", resp, orig);
    wait_clk(4);
    spi_frame(c2, 16, 8, 1, 0, 0, '0, resp, eresp, oe_ok);
    check("b2b_second_resp", resp, 16'h5555);
    wait_clk(6);
    check("b2b_rx", rx_data, model_rx);

    // Randomized frames: lengths, phases, payloads and optional clears.
    for (int k = 0; k < 10; k++) begin
      tx_data = W'($urandom);
      ph      = int'($urandom_range(5, 10));
      nb      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : W;
      c1      = W'($urandom);
      if (c1 == model_rx) c1 = ~c1;
      if ($urandom_range(0, 1) == 1) clear_rdy();
      spi_frame(c1, nb, ph, 1, 0, 0, '0, resp, eresp, oe_ok);
      if (nb >= W) check("rand_miso_word", resp, eresp);
      wait_clk(6);
      check("rand_rx", rx_data, model_rx);
      check1("rand_rdy", rdy, model_rdy);
    end

    wait_clk(10);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
